eth_rx_crc_check: RTL
=====================

// Module: eth_rx_crc_check
// PURPOSE
//  Receive-side counterpart of the TX CRC32 generator: checks the Ethernet FCS of a byte stream from the RX MAC/PHY parser.
//  Strips the 4 FCS bytes, forwards payload downstream with an end-of-frame good/bad flag, reports per-frame length/CRC status.
//  Sits between the GMII byte deframer and the UDP/IP RX parser.
// PARAMETERS
//  MIN_LEN  64    min legal frame length in bytes incl. FCS; shorter -> length error
//  MAX_LEN  1522  max legal frame length in bytes incl. FCS; longer -> length error (bytes still forwarded)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  rx_vld       in   1   input byte valid; sof/eof/data sampled only when high
//  rx_sof       in   1   first byte of frame
//  rx_eof       in   1   last byte of frame (last FCS byte)
//  rx_data      in   8   frame byte, wire order (bit0 first)
//  out_vld      out  1   payload byte valid
//  out_sof      out  1   first payload byte
//  out_eof      out  1   last payload byte / terminating beat
//  out_err      out  1   on out_eof beat: 1 = frame bad (CRC, length or abort)
//  out_data     out  8   payload byte
//  chk_done     out  1   1-cycle pulse: frame status valid
//  chk_ok       out  1   CRC good and length legal; held until next chk_done
//  chk_err_crc  out  1   CRC residue mismatch; held
//  chk_err_len  out  1   runt, oversize, or aborted frame; held
//  frame_len    out  16  bytes incl. FCS, saturates at 16'hFFFF; held
// BEHAVIOUR
//  Reset: every output 0; FSM IDLE; CRC reg 32'hFFFF_FFFF; delay line and counters cleared; no eof emitted for frame in flight.
//  FSM IDLE -> RECV on rx_vld&rx_sof; RECV -> IDLE on rx_vld&rx_eof. rx_eof in IDLE ignored; gaps (rx_vld=0) hold all state.
//  CRC: same polynomial/bit order as TX generator (data bit-reversed, MSB-first register, no final invert in register).
//   On sof byte, crc <= step(32'hFFFF_FFFF, data); else crc <= step(crc, data).
//   On eof byte, good iff step(crc, data) == 32'hC704_DD7B (residue); on a 1-byte frame use init for crc.
//  Delay line: 4-byte shift register. Input byte n (n>=5) -> output byte n-4 one cycle later; out_sof on output byte 1.
//   Eof byte N: out byte N-4 emitted next cycle with out_eof=1, out_err=~ok; FCS bytes dropped.
//  chk_done pulses the cycle after the eof byte (same cycle as out_eof); status/frame_len update then.
//  Length error if frame_len < MIN_LEN or > MAX_LEN; frames of <=4 bytes emit no output beats, only chk_done with err_len=1.
//  rx_sof while RECV (abort): chk_done next cycle, chk_err_len=1, chk_ok=0, chk_err_crc=0;
//   if >=1 payload byte already out: one beat out_vld=1, out_eof=1, out_err=1, out_data=8'h00; new frame starts on that sof byte.
//  rx_sof&rx_eof same cycle: 1-byte frame, len error, no output beats.
// CONFIGURATION
//  RX_CRC_STATS_EN defined: adds outputs stat_good[31:0] and stat_bad[31:0]; +1 on each chk_done with chk_ok=1 / chk_ok=0;
//   wrap at 2^32; cleared by rst only.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/include eth_pkg: CRC32_INIT=32'hFFFF_FFFF, CRC32_RESIDUE=32'hC704_DD7B, FSM state encoding (IDLE, RECV).
//  Sub-module crc32_d8_step: pure combinational byte step (crc_in, data_in -> crc_out), shareable with the TX generator.
//  Top holds FSM, CRC reg, 4-byte delay line, length counter, status regs, optional stats.
// TESTING
//  Frame 31..39 (ASCII "123456789") + FCS 26 39 F4 CB, MIN_LEN=13 -> out 31..39, eof on 39, out_err=0, chk_ok=1, frame_len=13.
//  Same frame, FCS last byte CA -> identical payload out, out_err=1, chk_err_crc=1, chk_ok=0.
//  64-byte valid frame with rx_vld gaps of 1-3 cycles, default params -> 60 payload beats, chk_ok=1, frame_len=64.
//  3-byte frame AA BB CC -> no out_vld beats, chk_done pulse, chk_err_len=1, frame_len=3.
//  20-byte frame, new sof at byte 10 -> terminating beat out_eof=1 out_err=1 data 00; next frame then checked normally.
//  rst asserted at byte 30 of a frame -> all outputs 0 next cycle, no out_eof; following frame passes; stats (if RX_CRC_STATS_EN) 0 then 1.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: constants and state encoding shared by the Ethernet CRC32 RX checker
// and the TX generator.
//   CRC32_INIT    : register value loaded on the first byte of a frame
//   CRC32_RESIDUE : register value left after a frame with a correct FCS
//   CRC32_POLY    : IEEE 802.3 polynomial in MSB-first form
//   rx_state_e    : RX framing state (IDLE between frames, RECV inside one)
package eth_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/crc32_d8_step.sv
// crc32_d8_step: one byte of the Ethernet CRC32, purely combinational.
// The register is kept MSB-first. Each data byte enters in wire order,
// bit 0 first. No final inversion is applied.
// Ports:
//   crc_in  [31:0] in  : current CRC register
//   data_in [7:0]  in  : byte in wire order (bit 0 transmitted first)
//   crc_out [31:0] out : register after absorbing data_in
module crc32_d8_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_v;

  // Bit-serial LFSR unrolled over the 8 bits of the byte, LSB first.
  always_comb begin
    crc_v = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_v[31] ^ data_in[i]) begin
        crc_v = {crc_v[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        crc_v = {crc_v[30:0], 1'b0};
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/eth_rx_crc_check.sv
// eth_rx_crc_check: checks the Ethernet FCS of an RX byte stream. It removes the
// 4 FCS bytes, forwards the payload with an end-of-frame good/bad flag, and
// reports the length and CRC status of each frame.
// Parameters: MIN_LEN / MAX_LEN are the legal frame lengths in bytes, FCS included.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rx_vld/rx_sof/rx_eof/rx_data  : input byte stream from the deframer
//   out_vld/out_sof/out_eof       : payload stream, 4 bytes behind the input
//   out_err/out_data              : bad-frame flag on the eof beat, payload byte
//   chk_done                      : one-cycle pulse when the frame status below is updated
//   chk_ok/chk_err_crc/chk_err_len: status flags, held until the next chk_done
//   frame_len                     : frame length incl. FCS, saturating, held
// Optional: define RX_CRC_STATS_EN to add the stat_good/stat_bad frame counters.
module eth_rx_crc_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [7:0]  rx_data,
  output logic        out_vld,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [7:0]  out_data,
  output logic        chk_done,
  output logic        chk_ok,
  output logic        chk_err_crc,
  output logic        chk_err_len,
  output logic [15:0] frame_len
`ifdef RX_CRC_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad
`endif
);

  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  rx_state_e        state_r, state_s;
  logic [31:0]      crc_r, crc_s;
  logic [3:0][7:0]  dly_r, dly_s;      // [3] is the oldest byte
  logic [15:0]      cnt_r, cnt_s;      // bytes of the current frame seen so far
  logic             pay_r, pay_s;      // at least one payload byte already forwarded
  logic [15:0]      cnt_inc_s;
  logic [31:0]      step_in_s, step_out_s;
  logic             good_s, len_bad_s;
  logic             out_vld_s, out_sof_s, out_eof_s, out_err_s;
  logic [7:0]       out_data_s;
  logic             chk_done_s, chk_ok_s, chk_err_crc_s, chk_err_len_s;
  logic [15:0]      frame_len_s;

  // A start-of-frame byte always restarts the CRC from the initial value.
  assign step_in_s = rx_sof ? CRC32_INIT : crc_r;

  crc32_d8_step u_step (
    .crc_in  (step_in_s),
    .data_in (rx_data),
    .crc_out (step_out_s)
  );

  assign good_s    = (step_out_s == CRC32_RESIDUE);
  assign cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
  // Frames of 4 bytes or fewer carry no payload. They are always a length error.
  assign len_bad_s = (cnt_inc_s < MIN_LEN_C) | (cnt_inc_s > MAX_LEN_C) |
                     (cnt_inc_s <= 16'd4);

  // Next-state, datapath and output decode for each accepted input byte.
  always_comb begin
    state_s       = state_r;
    crc_s         = crc_r;
    dly_s         = dly_r;
    cnt_s         = cnt_r;
    pay_s         = pay_r;
    out_vld_s     = 1'b0;
    out_sof_s     = 1'b0;
    out_eof_s     = 1'b0;
    out_err_s     = 1'b0;
    out_data_s    = 8'h00;
    chk_done_s    = 1'b0;
    chk_ok_s      = chk_ok;
    chk_err_crc_s = chk_err_crc;
    chk_err_len_s = chk_err_len;
    frame_len_s   = frame_len;
    if (rx_vld && rx_sof) begin
      if (state_r == RECV) begin
        // Abort: close the interrupted frame. If it already emitted payload,
        // send a terminating error beat.
        chk_done_s    = 1'b1;
        chk_ok_s      = 1'b0;
        chk_err_crc_s = 1'b0;
        chk_err_len_s = 1'b1;
        frame_len_s   = cnt_r;
        if (pay_r) begin
          out_vld_s = 1'b1;
          out_eof_s = 1'b1;
          out_err_s = 1'b1;
        end else begin
          out_vld_s = 1'b0;
        end
      end else begin
        chk_done_s = 1'b0;
      end
      crc_s = step_out_s;
      dly_s = {dly_r[2:0], rx_data};
      cnt_s = 16'd1;
      pay_s = 1'b0;
      if (rx_eof) begin
        // Single-byte frame: always a runt, and it produces no output beats.
        state_s       = IDLE;
        chk_done_s    = 1'b1;
        chk_ok_s      = 1'b0;
        chk_err_crc_s = ~good_s;
        chk_err_len_s = 1'b1;
        frame_len_s   = 16'd1;
      end else begin
        state_s = RECV;
      end
    end else if (rx_vld && (state_r == RECV)) begin
      crc_s = step_out_s;
      dly_s = {dly_r[2:0], rx_data};
      cnt_s = cnt_inc_s;
      // From the 5th byte on, the oldest delayed byte is payload.
      if (cnt_r >= 16'd4) begin
        out_vld_s  = 1'b1;
        out_sof_s  = (cnt_r == 16'd4);
        out_data_s = dly_r[3];
        pay_s      = 1'b1;
      end else begin
        pay_s = pay_r;
      end
      if (rx_eof) begin
        state_s       = IDLE;
        chk_done_s    = 1'b1;
        chk_ok_s      = good_s & ~len_bad_s;
        chk_err_crc_s = ~good_s;
        chk_err_len_s = len_bad_s;
        frame_len_s   = cnt_inc_s;
        out_eof_s     = (cnt_r >= 16'd4);
        out_err_s     = (cnt_r >= 16'd4) & ~(good_s & ~len_bad_s);
      end else begin
        state_s = RECV;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      crc_r       <= CRC32_INIT;
      dly_r       <= '0;
      cnt_r       <= 16'd0;
      pay_r       <= 1'b0;
      out_vld     <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_err     <= 1'b0;
      out_data    <= 8'h00;
      chk_done    <= 1'b0;
      chk_ok      <= 1'b0;
      chk_err_crc <= 1'b0;
      chk_err_len <= 1'b0;
      frame_len   <= 16'd0;
    end else begin
      state_r     <= state_s;
      crc_r       <= crc_s;
      dly_r       <= dly_s;
      cnt_r       <= cnt_s;
      pay_r       <= pay_s;
      out_vld     <= out_vld_s;
      out_sof     <= out_sof_s;
      out_eof     <= out_eof_s;
      out_err     <= out_err_s;
      out_data    <= out_data_s;
      chk_done    <= chk_done_s;
      chk_ok      <= chk_ok_s;
      chk_err_crc <= chk_err_crc_s;
      chk_err_len <= chk_err_len_s;
      frame_len   <= frame_len_s;
    end
  end

`ifdef RX_CRC_STATS_EN
  // Good/bad frame counters. They update together with chk_done and wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good <= 32'd0;
      stat_bad  <= 32'd0;
    end else if (chk_done_s && chk_ok_s) begin
      stat_good <= stat_good + 32'd1;
    end else if (chk_done_s) begin
      stat_bad  <= stat_bad + 32'd1;
    end else begin
      stat_good <= stat_good;
    end
  end
`endif

endmodule
